// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, opcode constants and arbiter state type for alu_arb
package alu_pkg;

    localparam int XLEN     = 32;
    localparam int ALU_OP_W = 6;

    localparam logic [1:0] ALU_CLS_ARITH = 2'b11;
    localparam logic [1:0] ALU_CLS_SHIFT = 2'b10;
    localparam logic [1:0] ALU_CLS_BOOL  = 2'b01;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 6'b110000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 6'b110001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } arb_state_e;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational 32-bit alu; class in op[5:4], function in op[3:0], unknown codes give 0
module alu
    import alu_pkg::*;
(
    input  logic [ALU_OP_W-1:0] op_i,
    input  logic [XLEN-1:0]     a_i,
    input  logic [XLEN-1:0]     b_i,
    output logic [XLEN-1:0]     y_o
);

    always_comb begin
        y_o = '0;
        case (op_i[5:4])
            ALU_CLS_ARITH: begin
                case (op_i[3:0])
                    4'h0:    y_o = a_i + b_i;
                    4'h1:    y_o = a_i - b_i;
                    default: y_o = '0;
                endcase
            end
            ALU_CLS_SHIFT: begin
                case (op_i[3:0])
                    4'h0:    y_o = a_i << b_i[4:0];
                    4'h1:    y_o = a_i >> b_i[4:0];
                    4'h2:    y_o = XLEN'($signed(a_i) >>> b_i[4:0]);
                    default: y_o = '0;
                endcase
            end
            ALU_CLS_BOOL: begin
                case (op_i[3:0])
                    4'h0:    y_o = a_i & b_i;
                    4'h1:    y_o = a_i | b_i;
                    4'h2:    y_o = a_i ^ b_i;
                    default: y_o = '0;
                endcase
            end
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_arb.sv
// rtl/alu_arb.sv - two requesters share one alu, round-robin, one op in flight
// ALU_ARB_FASTPATH_EN: skip EXEC, compute from the granted request and register on the accept edge
module alu_arb
    import alu_pkg::*;
#(
    parameter int RR_INIT = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [1:0]               req_valid_i,
    output logic [1:0]               req_ready_o,
    input  logic [1:0][ALU_OP_W-1:0] req_op_i,
    input  logic [1:0][XLEN-1:0]     req_a_i,
    input  logic [1:0][XLEN-1:0]     req_b_i,
    output logic [1:0]               rsp_valid_o,
    input  logic [1:0]               rsp_ready_i,
    output logic [XLEN-1:0]          rsp_result_o
);

    localparam logic RR_INIT_BIT = (RR_INIT != 0);

    arb_state_e          state_q, state_d;
    logic [ALU_OP_W-1:0] op_q, op_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                port_q, port_d;
    logic                last_q, last_d;

    logic                grant_port;
    logic [ALU_OP_W-1:0] alu_op;
    logic [XLEN-1:0]     alu_a;
    logic [XLEN-1:0]     alu_b;
    logic [XLEN-1:0]     alu_y;

    // Lone requester always wins; a tie goes to the port not served last.
    always_comb begin
        if (&req_valid_i) begin
            grant_port = ~last_q;
        end else begin
            grant_port = req_valid_i[1];
        end
    end

`ifdef ALU_ARB_FASTPATH_EN
    always_comb begin
        if (state_q == ST_IDLE) begin
            alu_op = req_op_i[grant_port];
            alu_a  = req_a_i[grant_port];
            alu_b  = req_b_i[grant_port];
        end else begin
            alu_op = op_q;
            alu_a  = a_q;
            alu_b  = b_q;
        end
    end
`else
    assign alu_op = op_q;
    assign alu_a  = a_q;
    assign alu_b  = b_q;
`endif

    alu u_alu (
        .op_i (alu_op),
        .a_i  (alu_a),
        .b_i  (alu_b),
        .y_o  (alu_y)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        port_d      = port_q;
        last_d      = last_q;
        req_ready_o = 2'b00;
        rsp_valid_o = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if ((|req_valid_i) && !rst_i) begin
                    req_ready_o[grant_port] = 1'b1;
                    op_d   = req_op_i[grant_port];
                    a_d    = req_a_i[grant_port];
                    b_d    = req_b_i[grant_port];
                    port_d = grant_port;
                    last_d = grant_port;
`ifdef ALU_ARB_FASTPATH_EN
                    result_d = alu_y;
                    state_d  = ST_RESP;
`else
                    state_d  = ST_EXEC;
`endif
                end
            end
            ST_EXEC: begin
                result_d = alu_y;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid_o[port_q] = 1'b1;
                if (rsp_ready_i[port_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rsp_result_o = result_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            port_q   <= 1'b0;
            last_q   <= RR_INIT_BIT;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            port_q   <= port_d;
            last_q   <= last_d;
        end
    end

endmodule

// File: tb/tb_alu_arb.sv
// tb/tb_alu_arb.sv - self-checking bench for alu_arb, directed scenarios plus randomized traffic against a reference model
module tb_alu_arb;
    import alu_pkg::*;

`ifdef ALU_ARB_FASTPATH_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic                     clk_i = 1'b0;
    logic                     rst_i;
    logic [1:0]               req_valid_i;
    logic [1:0]               req_ready_o;
    logic [1:0][ALU_OP_W-1:0] req_op_i;
    logic [1:0][XLEN-1:0]     req_a_i;
    logic [1:0][XLEN-1:0]     req_b_i;
    logic [1:0]               rsp_valid_o;
    logic [1:0]               rsp_ready_i;
    logic [XLEN-1:0]          rsp_result_o;

    int checks   = 0;
    int failures = 0;

    alu_arb #(.RR_INIT(0)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_op_i     (req_op_i),
        .req_a_i      (req_a_i),
        .req_b_i      (req_b_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_result_o (rsp_result_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] wide;
        wide = {{32{a[31]}}, a} >> b[4:0];
        case (op)
            6'b110000: return a + b;
            6'b110001: return a - b;
            6'b100000: return a << b[4:0];
            6'b100001: return a >> b[4:0];
            6'b100010: return wide[31:0];
            6'b010000: return a & b;
            6'b010001: return a | b;
            6'b010010: return a ^ b;
            default:   return 32'd0;
        endcase
    endfunction

    task automatic wait_rsp(output int n);
        n = 99;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk_i);
            #1;
            if (rsp_valid_o != 2'b00) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk_i);
        req_valid_i = 2'b11;
        #1;
        checks++;
        if (req_ready_o !== 2'b00) $display("FAIL reset_ready got=%b exp=00", req_ready_o);
        if (req_ready_o !== 2'b00) failures++;
        checks++;
        if (rsp_valid_o !== 2'b00 || rsp_result_o !== 32'd0) begin
            $display("FAIL reset_rsp got valid=%b result=%h exp valid=00 result=0", rsp_valid_o, rsp_result_o);
            failures++;
        end
        @(negedge clk_i);
        req_valid_i = 2'b00;
        rst_i = 1'b0;
        #1;
        checks++;
        if (dut.state_q !== ST_IDLE) begin
            $display("FAIL reset_state got=%0d exp=IDLE", dut.state_q);
            failures++;
        end
    endtask

    task automatic test_add;
        int n;
        @(negedge clk_i);
        req_valid_i = 2'b01; req_op_i[0] = ALU_ADD; req_a_i[0] = 32'd5; req_b_i[0] = 32'd3;
        rsp_ready_i = 2'b11;
        #1;
        checks++;
        if (req_ready_o !== 2'b01) begin
            $display("FAIL add_ready got=%b exp=01", req_ready_o);
            failures++;
        end
        @(posedge clk_i); #1;
        req_valid_i = 2'b00;
        wait_rsp(n);
        checks++;
        if (n != LAT) begin
            $display("FAIL add_latency got=%0d exp=%0d", n, LAT);
            failures++;
        end
        checks++;
        if (rsp_valid_o !== 2'b01 || rsp_result_o !== 32'd8) begin
            $display("FAIL add_rsp got valid=%b result=%0d exp valid=01 result=8", rsp_valid_o, rsp_result_o);
            failures++;
        end
        @(posedge clk_i); #1;
        checks++;
        if (dut.state_q !== ST_IDLE || rsp_valid_o !== 2'b00) begin
            $display("FAIL add_back_idle got state=%0d valid=%b exp IDLE 00", dut.state_q, rsp_valid_o);
            failures++;
        end
    endtask

    task automatic test_rr_order;
        int n;
        @(negedge clk_i);
        rst_i = 1'b1;
        req_valid_i = 2'b11;
        req_op_i[1] = ALU_SUB; req_a_i[1] = 32'd10;         req_b_i[1] = 32'd3;
        req_op_i[0] = ALU_ADD; req_a_i[0] = 32'hFFFF_FFFF;  req_b_i[0] = 32'd1;
        rsp_ready_i = 2'b11;
        #1;
        checks++;
        if (req_ready_o !== 2'b00) begin
            $display("FAIL rr_ready_in_reset got=%b exp=00", req_ready_o);
            failures++;
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        checks++;
        if (req_ready_o !== 2'b10) begin
            $display("FAIL rr_first_grant got=%b exp=10", req_ready_o);
            failures++;
        end
        @(posedge clk_i); #1;
        req_valid_i = 2'b01;
        wait_rsp(n);
        checks++;
        if (rsp_valid_o !== 2'b10 || rsp_result_o !== 32'd7) begin
            $display("FAIL rr_sub_rsp got valid=%b result=%0d exp valid=10 result=7", rsp_valid_o, rsp_result_o);
            failures++;
        end
        @(negedge clk_i); #1;
        checks++;
        if (req_ready_o !== 2'b01) begin
            $display("FAIL rr_second_grant got=%b exp=01", req_ready_o);
            failures++;
        end
        @(posedge clk_i); #1;
        req_valid_i = 2'b00;
        wait_rsp(n);
        checks++;
        if (rsp_valid_o !== 2'b01 || rsp_result_o !== 32'd0) begin
            $display("FAIL rr_wrap_rsp got valid=%b result=%h exp valid=01 result=0", rsp_valid_o, rsp_result_o);
            failures++;
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_backpressure;
        int n;
        logic [31:0] a, b, exp0;
        a = $urandom; b = $urandom;
        exp0 = a ^ b;
        @(negedge clk_i);
        rsp_ready_i = 2'b00;
        req_valid_i = 2'b01; req_op_i[0] = 6'b010010; req_a_i[0] = a; req_b_i[0] = b;
        req_op_i[1] = 6'b010001; req_a_i[1] = 32'h0000_00F0; req_b_i[1] = 32'h0000_000F;
        #1;
        checks++;
        if (req_ready_o !== 2'b01) begin
            $display("FAIL bp_accept got=%b exp=01", req_ready_o);
            failures++;
        end
        @(posedge clk_i); #1;
        req_valid_i = 2'b10;
        wait_rsp(n);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(negedge clk_i);
                rsp_ready_i = (i % 2 == 1) ? 2'b10 : 2'b00;
                #1;
            end
            checks++;
            if (rsp_valid_o !== 2'b01 || rsp_result_o !== exp0 || req_ready_o !== 2'b00) begin
                $display("FAIL bp_hold cyc=%0d got valid=%b result=%h ready=%b exp valid=01 result=%h ready=00",
                         i, rsp_valid_o, rsp_result_o, req_ready_o, exp0);
                failures++;
            end
        end
        @(negedge clk_i);
        rsp_ready_i = 2'b01;
        @(posedge clk_i); #1;
        checks++;
        if (req_ready_o !== 2'b10) begin
            $display("FAIL bp_port1_accept got=%b exp=10", req_ready_o);
            failures++;
        end
        @(posedge clk_i); #1;
        req_valid_i = 2'b00;
        rsp_ready_i = 2'b11;
        wait_rsp(n);
        checks++;
        if (rsp_valid_o !== 2'b10 || rsp_result_o !== 32'h0000_00FF) begin
            $display("FAIL bp_port1_rsp got valid=%b result=%h exp valid=10 result=000000ff", rsp_valid_o, rsp_result_o);
            failures++;
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset_in_exec;
        int seen;
        @(negedge clk_i);
        req_valid_i = 2'b01; req_op_i[0] = ALU_ADD; req_a_i[0] = 32'd100; req_b_i[0] = 32'd23;
        rsp_ready_i = 2'b11;
        @(posedge clk_i); #1;
        req_valid_i = 2'b00;
        rst_i = 1'b1;
        #1;
        checks++;
        if (rsp_valid_o !== 2'b00 || dut.state_q !== ST_IDLE || req_ready_o !== 2'b00) begin
            $display("FAIL rst_exec_abort got valid=%b state=%0d ready=%b exp 00 IDLE 00",
                     rsp_valid_o, dut.state_q, req_ready_o);
            failures++;
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i); #1;
            if (rsp_valid_o !== 2'b00) seen++;
        end
        checks++;
        if (seen != 0) begin
            $display("FAIL rst_exec_no_rsp got=%0d valid cycles exp=0", seen);
            failures++;
        end
    endtask

    task automatic test_class00;
        int n;
        logic [31:0] b;
        b = $urandom;
        @(negedge clk_i);
        req_valid_i = 2'b01; req_op_i[0] = 6'b000000; req_a_i[0] = 32'd7; req_b_i[0] = b;
        rsp_ready_i = 2'b11;
        @(posedge clk_i); #1;
        req_valid_i = 2'b00;
        wait_rsp(n);
        checks++;
        if (n != LAT || rsp_valid_o !== 2'b01 || rsp_result_o !== 32'd0) begin
            $display("FAIL class00 got lat=%0d valid=%b result=%h exp lat=%0d valid=01 result=0",
                     n, rsp_valid_o, rsp_result_o, LAT);
            failures++;
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_random;
        logic [5:0]  ops [10];
        logic [1:0]  pend_v;
        logic [5:0]  pend_op [2];
        logic [31:0] pend_a [2];
        logic [31:0] pend_b [2];
        logic        busy, port, last, g;
        int          delay;
        logic [31:0] exp_res;
        logic [1:0]  exp_ready, exp_rspv;
        ops = '{6'b110000, 6'b110001, 6'b100000, 6'b100001, 6'b100010,
                6'b010000, 6'b010001, 6'b010010, 6'b000000, 6'b111111};
        @(negedge clk_i);
        rst_i = 1'b1;
        req_valid_i = 2'b00;
        @(negedge clk_i);
        rst_i = 1'b0;
        pend_v = 2'b00; busy = 1'b0; port = 1'b0; last = 1'b0; g = 1'b0; delay = 0; exp_res = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc > 0) @(negedge clk_i);
            for (int p = 0; p < 2; p++) begin
                if (!pend_v[p] && $urandom_range(0, 2) != 0) begin
                    pend_v[p]  = 1'b1;
                    pend_op[p] = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
                    pend_a[p]  = $urandom;
                    pend_b[p]  = $urandom;
                end
                req_op_i[p] = pend_op[p];
                req_a_i[p]  = pend_a[p];
                req_b_i[p]  = pend_b[p];
            end
            req_valid_i = pend_v;
            rsp_ready_i = 2'($urandom_range(0, 3));
            #1;
            exp_ready = 2'b00;
            exp_rspv  = 2'b00;
            if (!busy) begin
                if (pend_v != 2'b00) begin
                    g = (pend_v == 2'b11) ? !last : pend_v[1];
                    exp_ready[g] = 1'b1;
                end
            end else if (delay == 0) begin
                exp_rspv[port] = 1'b1;
            end
            checks++;
            if (req_ready_o !== exp_ready) begin
                $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, req_ready_o, exp_ready);
                failures++;
            end
            checks++;
            if (rsp_valid_o !== exp_rspv) begin
                $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid_o, exp_rspv);
                failures++;
            end
            if (exp_rspv != 2'b00) begin
                checks++;
                if (rsp_result_o !== exp_res) begin
                    $display("FAIL rnd_result cyc=%0d got=%h exp=%h", cyc, rsp_result_o, exp_res);
                    failures++;
                end
            end
            if (!busy) begin
                if (pend_v != 2'b00) begin
                    busy    = 1'b1;
                    port    = g;
                    last    = g;
                    delay   = LAT - 1;
                    exp_res = ref_alu(pend_op[g], pend_a[g], pend_b[g]);
                    pend_v[g] = 1'b0;
                end
            end else if (delay > 0) begin
                delay--;
            end else if (rsp_ready_i[port]) begin
                busy = 1'b0;
            end
        end
        @(negedge clk_i);
        req_valid_i = 2'b00;
        rsp_ready_i = 2'b11;
    endtask

    initial begin
        rst_i       = 1'b1;
        req_valid_i = 2'b00;
        req_op_i    = '0;
        req_a_i     = '0;
        req_b_i     = '0;
        rsp_ready_i = 2'b00;
        test_reset();
        test_add();
        test_rr_order();
        test_backpressure();
        test_reset_in_exec();
        test_class00();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arb.md
ALU_ARB -- requirements
Module: alu_arb

Interface
REQ-001 Parameter: RR_INIT, default 0, index of the port that has lowest priority after reset.
REQ-002 clk_i  input  1  system clock, all state rising-edge triggered.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 req_valid_i  input  2  per-port request valid; port k uses bit k.
REQ-005 req_ready_o  output  2  per-port request accepted this cycle.
REQ-006 req_op_i  input  2x6  per-port ALU opcode; bits [5:4] give the class (11 arith, 10 shift, 01 bool).
REQ-007 req_a_i, req_b_i  input  2x32  per-port operands.
REQ-008 rsp_valid_o  output  2  per-port result valid.
REQ-009 rsp_ready_i  input  2  per-port result consumed.
REQ-010 rsp_result_o  output  32  result, shared by both ports, meaningful only for the port whose rsp_valid_o is high.

Function
REQ-011 Shall share one ALU instance between 2 requesters, with at most one operation in flight in total.
REQ-012 FSM states: IDLE, EXEC, RESP.
REQ-013 IDLE: if any req_valid_i bit is high, grant one port, set its req_ready_o bit in the same cycle (combinational), latch op/a/b/port into registers, and go to EXEC; else stay in IDLE.
REQ-014 req_ready_o shall be 0 in every state except IDLE, and at most one bit shall be high.
REQ-015 Arbitration is round-robin: when both ports request, grant the port other than the last-granted one; last-granted updates on accept.
REQ-016 EXEC: ALU operands come from the latched registers; capture the ALU output into the result register and go to RESP (one cycle).
REQ-017 RESP: assert rsp_valid_o for the granted port only; hold the result stable until rsp_ready_i for that port is high, then go to IDLE on that edge.
REQ-018 rsp_ready_i for the non-granted port shall be ignored.
REQ-019 Latency: accept at edge N gives rsp_valid_o at N+2; peak throughput is one operation per 3 cycles.
REQ-020 A request presented while the block is busy shall see req_ready_o=0; the requester holds valid and payload (no drop, no queueing).
REQ-021 Opcode class 00 is not trapped: the block returns the ALU output (0) with a normal response.
REQ-022 Arithmetic is 32-bit modulo; shift amount uses b[4:0]; the block adds no width extension.

Reset
REQ-023 Asserting rst_i in any state, including EXEC or RESP, immediately forces IDLE and aborts any in-flight response without retiring it.
REQ-024 Reset values: req_ready_o=0 (until reset deasserts), rsp_valid_o=0, rsp_result_o=0, operand registers=0, last-granted=RR_INIT.

Configuration
REQ-025 Macro ALU_ARB_FASTPATH_EN.
- Defined: the EXEC state is removed; the ALU is fed from the granted request mux; the result is registered on the accept edge; rsp_valid_o appears at N+1.
- Undefined: behaviour per REQ-016/REQ-019.

Structure
REQ-026 Package alu_pkg shall hold:
- class constants ALU_CLS_ARITH=2'b11, ALU_CLS_SHIFT=2'b10, ALU_CLS_BOOL=2'b01;
- ALU_ADD=6'b110000, ALU_SUB=6'b110001;
- the FSM state enum;
- width constants XLEN=32 and ALU_OP_W=6.
REQ-027 Exactly one sub-module: the existing alu, instantiated once; no second ALU.

Verification
REQ-028 Port0 ADD a=5 b=3, rsp_ready_i held high -> rsp_valid_o=01 two cycles after accept, result=8, FSM back to IDLE.
REQ-029 Both ports valid at reset exit with RR_INIT=0 -> port1 is granted first, then port0. Port1 SUB 10-3 returns 7; port0 ADD 0xFFFFFFFF+1 returns 0 (wrap).
REQ-030 Port0 result with rsp_ready_i low for 5 cycles -> rsp_valid_o and result stay stable, port1 req_ready_o stays 0, and port1 is accepted on the first IDLE cycle after the handshake.
REQ-031 rst_i asserted while in EXEC -> rsp_valid_o=0 immediately, FSM in IDLE, and no response is issued after release.
REQ-032 Opcode 6'b000000 with a=7 -> normal response with result 0.
REQ-033 With ALU_ARB_FASTPATH_EN defined, rerun REQ-028 -> rsp_valid_o one cycle after accept, result=8.
